// File: rtl/ddr3_request_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_request_bridge
//  Purpose  : Responder side of the pixel-pipeline DDR3 request interface.
//             It takes single-word read/write requests from a Canny stage and
//             executes each one as an Avalon-MM transaction on the HPS/FPGA
//             SDRAM port. Only one request is serviced at a time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock, reset         : sole clock, synchronous active-high reset
//    sdram_address        : client word (pixel) address
//    rd_en / wr_en        : one-cycle request pulses (both = write then read)
//    write_data_input     : write word, sampled together with wr_en
//    read_data            : last returned read word (held until next read)
//    write_complete       : one-cycle pulse after Avalon accepts the write
//    read_complete        : one-cycle pulse when read_data is fresh
//    avm_*                : Avalon-MM master, byte addressed, all registered
//    busy                 : high whenever the FSM is not IDLE
//    req_dropped          : sticky, a request arrived while busy
//    timeout_err          : sticky read-timeout flag
//  Build option
//    DDR3_BRIDGE_TIMEOUT_EN : when defined, a read that sees no readdatavalid
//                             within TIMEOUT_CYCLES cycles of RD_WAIT completes
//                             with 32'hDEAD_BEEF and sets timeout_err. When
//                             undefined RD_WAIT waits forever and timeout_err
//                             is tied low.
// ============================================================================
module ddr3_request_bridge #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h3000_0000,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   sdram_address,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   write_data_input,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    write_complete,
    output logic                    read_complete,
    output logic [ADDR_WIDTH-1:0]   avm_address,
    output logic                    avm_read,
    output logic                    avm_write,
    output logic [DATA_WIDTH-1:0]   avm_writedata,
    output logic [DATA_WIDTH/8-1:0] avm_byteenable,
    input  logic [DATA_WIDTH-1:0]   avm_readdata,
    input  logic                    avm_readdatavalid,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    req_dropped,
    output logic                    timeout_err
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_WR_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RD_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_RD_WAIT  = 2'd3;

    localparam logic [DATA_WIDTH-1:0] c_TIMEOUT_WORD = DATA_WIDTH'(32'hDEAD_BEEF);

    // A zero-length timeout window has no meaning; refuse to elaborate.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
        $error("ddr3_request_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_rd_pending;

    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_write_complete;
    logic                  r_read_complete;
    logic [ADDR_WIDTH-1:0] r_avm_address;
    logic                  r_avm_read;
    logic                  r_avm_write;
    logic [DATA_WIDTH-1:0] r_avm_writedata;
    logic                  r_busy;
    logic                  r_req_dropped;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_wr_done;
    logic                  w_rd_capture;
    logic                  w_timeout;
    logic                  w_timeout_hit;
    logic [ADDR_WIDTH-1:0] w_xlat_address;

    // Word address to byte address inside the frame-buffer window; the sum
    // wraps naturally at ADDR_WIDTH bits.
    assign w_xlat_address = BASE_ADDR + (sdram_address << 2);

    assign w_req    = rd_en | wr_en;
    assign w_accept = (r_state == c_ST_IDLE) && w_req;

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_TMO_W-1:0] r_timeout_cnt;
    logic               r_timeout_err;

    // Counts RD_WAIT cycles; cleared in every other state so each read
    // starts a fresh window.
    always_ff @(posedge clock) begin
        if (reset || (r_state != c_ST_RD_WAIT)) begin
            r_timeout_cnt <= '0;
        end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
        end
    end

    assign w_timeout_hit = (r_timeout_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and per-cycle event strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_wr_done    = 1'b0;
        w_rd_capture = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Write has priority; a simultaneous read is parked in
                // r_rd_pending and issued after the write completes.
                if (wr_en) begin
                    w_state_next = c_ST_WR_ISSUE;
                end else if (rd_en) begin
                    w_state_next = c_ST_RD_ISSUE;
                end
            end
            c_ST_WR_ISSUE: begin
                if (!avm_waitrequest) begin
                    w_wr_done    = 1'b1;
                    w_state_next = r_rd_pending ? c_ST_RD_ISSUE : c_ST_IDLE;
                end
            end
            c_ST_RD_ISSUE: begin
                if (!avm_waitrequest) begin
                    // Zero-latency slaves may return data in the accept cycle.
                    if (avm_readdatavalid) begin
                        w_rd_capture = 1'b1;
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_state_next = c_ST_RD_WAIT;
                    end
                end
            end
            c_ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    w_rd_capture = 1'b1;
                    w_state_next = c_ST_IDLE;
                end else if (w_timeout_hit) begin
                    w_timeout    = 1'b1;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs. Avalon command bits are decoded from the next
    // state so they rise the cycle after a request and never see a
    // combinational path from the client or the slave.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_data      <= '0;
            r_write_complete <= 1'b0;
            r_read_complete  <= 1'b0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_busy           <= 1'b0;
            r_req_dropped    <= 1'b0;
            r_rd_pending     <= 1'b0;
        end else begin
            r_write_complete <= w_wr_done;
            r_read_complete  <= w_rd_capture | w_timeout;
            r_avm_write      <= (w_state_next == c_ST_WR_ISSUE);
            r_avm_read       <= (w_state_next == c_ST_RD_ISSUE);
            r_busy           <= (w_state_next != c_ST_IDLE);

            if (w_rd_capture) begin
                r_read_data <= avm_readdata;
            end else if (w_timeout) begin
                r_read_data <= c_TIMEOUT_WORD;
            end

            if (w_accept) begin
                r_avm_address <= w_xlat_address;
                if (wr_en) begin
                    r_avm_writedata <= write_data_input;
                end
            end

            if (w_accept && wr_en && rd_en) begin
                r_rd_pending <= 1'b1;
            end else if (w_wr_done) begin
                r_rd_pending <= 1'b0;
            end

            if ((r_state != c_ST_IDLE) && w_req) begin
                r_req_dropped <= 1'b1;
            end
        end
    end

    assign read_data      = r_read_data;
    assign write_complete = r_write_complete;
    assign read_complete  = r_read_complete;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = '1;
    assign busy           = r_busy;
    assign req_dropped    = r_req_dropped;

endmodule
`default_nettype wire

// File: doc/ddr3_request_bridge.md
# ddr3_request_bridge

Responder side of the pixel-pipeline DDR3 request interface: accepts single-word read/write requests from a Canny stage, such as the hysteresis stage, and executes them as Avalon-MM transactions on the HPS/FPGA SDRAM port. It owns address translation into the frame-buffer region, wait-request handling and completion signalling. It services exactly one request at a time.

## Interface
- `ADDR_WIDTH`, 32: width of client word address and Avalon byte address
- `DATA_WIDTH`, 32: data word width (byteenable width = DATA_WIDTH/8)
- `BASE_ADDR`, 32'h3000_0000: byte base of the frame-buffer region
- `TIMEOUT_CYCLES`, 1024: read timeout limit (used only with the macro)

Ports:
- `clock` in 1: sole clock
- `reset` in 1: synchronous, active-high
- `sdram_address` in ADDR_WIDTH: client word (pixel) address
- `rd_en` in 1: one-cycle read request pulse
- `wr_en` in 1: one-cycle write request pulse
- `write_data_input` in DATA_WIDTH: write data, sampled with `wr_en`
- `read_data` out DATA_WIDTH: last returned read word
- `write_complete` out 1: one-cycle pulse when a write is accepted by Avalon
- `read_complete` out 1: one-cycle pulse when `read_data` is valid
- `avm_address` out ADDR_WIDTH: Avalon byte address
- `avm_read` / `avm_write` out 1: Avalon commands
- `avm_writedata` out DATA_WIDTH; `avm_byteenable` out DATA_WIDTH/8, constant all-ones
- `avm_readdata` in DATA_WIDTH; `avm_readdatavalid` in 1; `avm_waitrequest` in 1
- `busy` out 1: high in every state except IDLE
- `req_dropped` out 1: sticky; set when a request arrives while busy
- `timeout_err` out 1: sticky read-timeout flag

## Operation
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- Address translation: `avm_address = BASE_ADDR + (sdram_address << 2)`, truncated to ADDR_WIDTH, wrapping mod 2^ADDR_WIDTH. Address and data are registered on request acceptance.
- IDLE + `wr_en` → WR_ISSUE. IDLE + `rd_en` → RD_ISSUE.
- IDLE + both `wr_en` and `rd_en` → WR_ISSUE with a pending read latched at the same address. After `write_complete`, the FSM goes directly to RD_ISSUE. The read returns the newly written word.
- WR_ISSUE: `avm_write` held while `avm_waitrequest`=1. On the accept cycle (waitrequest=0) → IDLE, or → RD_ISSUE if a read is pending.
- RD_ISSUE: `avm_read` held while waitrequest=1. On accept → RD_WAIT.
- RD_WAIT: on `avm_readdatavalid`, capture `avm_readdata` into `read_data` → IDLE. A readdatavalid in the RD_ISSUE accept cycle is also captured, going directly to IDLE. Readdatavalid in any other state is ignored.
- Requests (`rd_en`/`wr_en`) sampled in any non-IDLE state are discarded and set `req_dropped`.
- `read_data` holds its value until the next read completes.
- Reset (any state): FSM → IDLE, pending read cleared, sticky flags cleared. Any Avalon transaction outstanding at reset is abandoned; its late readdatavalid is ignored.

## Timing
- Reset values: `read_data`=0, `write_complete`=0, `read_complete`=0, `avm_read`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `busy`=0, `req_dropped`=0, `timeout_err`=0. `avm_byteenable` is all-ones.
- Request at cycle N → `avm_write`/`avm_read` high from N+1.
- Write accepted at cycle M → `write_complete`=1 at M+1 only. The bridge is IDLE at M+1 and can accept a new request sampled at M+1.
- Readdatavalid at cycle R → `read_data` updated and `read_complete`=1 at R+1. The bridge is IDLE at R+1.
- Minimum turnaround with waitrequest=0 and 1-cycle read latency:
  - write: request to `write_complete` = 2 cycles
  - read: request to `read_complete` = 3 cycles
- `avm_*` outputs are driven from registers only, with no combinational input-to-Avalon path.

## Configuration
- `DDR3_BRIDGE_TIMEOUT_EN` defined:
  - A counter runs in RD_WAIT.
  - After TIMEOUT_CYCLES cycles with no readdatavalid, the bridge sets `read_data`=32'hDEAD_BEEF, pulses `read_complete`, sets `timeout_err`, and returns to IDLE.
  - A late readdatavalid from that read is ignored.
- Undefined: RD_WAIT waits indefinitely, no counter is synthesized, and `timeout_err` is tied 0.

## Test plan
- Write: `wr_en` with address 5, data 0xAB, waitrequest=0 → `avm_write` with `avm_address` 0x3000_0014 and `avm_writedata` 0xAB for 1 cycle; `write_complete` 2 cycles after the request.
- Read with backpressure: `rd_en` at address 5, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with data 0xAB → `avm_read` held 4 cycles; `read_data`=0xAB and one `read_complete` pulse.
- Simultaneous `wr_en`+`rd_en` at address 7, data 0x30 → write issued first, `write_complete`, then read at 0x3000_001C; `read_complete` with the memory-model value 0x30.
- `rd_en` pulsed while in RD_WAIT → no second `avm_read`; `req_dropped`=1 until reset.
- Reset asserted in RD_WAIT, memory returns readdatavalid 2 cycles later → no `read_complete`, `read_data`=0, `busy`=0.
- With `DDR3_BRIDGE_TIMEOUT_EN` and TIMEOUT_CYCLES=16, memory never responds → `read_complete` 16 cycles into RD_WAIT, `read_data`=0xDEAD_BEEF, `timeout_err`=1.
